mc_maindec: RTL and testbench

Multicycle main controller for the MIPS core. It decodes the 6-bit opcode of the instruction register and sequences fetch, decode, execute, memory and writeback cycles. Per cycle it drives the datapath enables and muxes, plus the 4-bit `aluop` consumed directly by the ALU-control decoder. It sits between the instruction register and the ALU decoder / datapath, and stalls on a memory-ready handshake.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/immop_dec.sv | 22 ++
 rtl/mc_maindec.sv | 129 ++++++++++++
 tb/tb_mc_maindec.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU operation codes and controller states.
// The ALU decoder uses the same ALU_* codes so both ends agree on the encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_LUI   = 4'b0111;
  localparam logic [3:0] ALU_RTYPE = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_MEMWB,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
  } state_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/immop_dec.sv
// Maps an immediate-form opcode to the ALU operation used in the IMMEX cycle.
module immop_dec
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  output logic [3:0] o_aluop
);

  // Non-immediate opcodes fall back to ADD so no undefined code is ever emitted.
  always_comb begin
    case (i_op)
      OP_ADDI: o_aluop = ALU_ADD;
      OP_SLTI: o_aluop = ALU_SLT;
      OP_ANDI: o_aluop = ALU_AND;
      OP_ORI:  o_aluop = ALU_OR;
      OP_XORI: o_aluop = ALU_XOR;
      OP_LUI:  o_aluop = ALU_LUI;
      default: o_aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the ALU operation code.
module mc_maindec
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] aluop,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_immAluop;

  immop_dec u_immop_dec (
    .i_op    (op),
    .o_aluop (w_immAluop)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) w_next = S_MEMADR;
        else if (op == OP_RTYPE)            w_next = S_EXECUTE;
        else if (op == OP_BEQ)              w_next = S_BRANCH;
        else if (is_imm_op(op))             w_next = S_IMMEX;
        else if (op == OP_J)                w_next = S_JUMP;
        else                                w_next = S_FETCH;
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:   if (mem_ready) w_next = S_FETCH;
      S_EXECUTE: w_next = S_ALUWB;
      S_IMMEX:   w_next = S_IMMWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Outputs are gated by reset so a write in progress is cut off the moment reset falls.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALU_ADD;
    illegal  = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          illegal = !((op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                      (op == OP_BEQ) || (op == OP_J) || is_imm_op(op));
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD:  iord = 1'b1;
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = ALU_RTYPE;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALU_SUB;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = w_immAluop;
        end
        S_IMMWB:  regwrite = 1'b1;
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: a per-instruction cycle model predicts every
// output each cycle, plus literal spot checks on key cycles.
module tb_mc_maindec;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluop;
  logic       illegal;

  logic [17:0] dutVec;
  logic [17:0] expVec;
  logic        checkEn;
  int          vecCount;
  int          missCount;
  logic [17:0] hist[$];

  mc_maindec dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .illegal   (illegal)
  );

  // Bit 17 pcwrite ... bit 0 illegal; see mk() for the full ordering.
  assign dutVec = {pcwrite, branch, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, pcsrc, aluop, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic pcw, br, io, mw, irw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, pcs,
                                     input logic [3:0] aop,
                                     input logic ill);
    return {pcw, br, io, mw, irw, rw, rd, m2r, asa, asb, pcs, aop, ill};
  endfunction

  function automatic logic isKnown(input logic [5:0] o);
    logic [5:0] known[11];
    known = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b001010, 6'b001100,
              6'b001101, 6'b001110, 6'b001111, 6'b100011, 6'b101011};
    foreach (known[i]) if (known[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic isImm(input logic [5:0] o);
    return (o[5:3] == 3'b001) && (o != 6'b001001) && (o != 6'b001011);
  endfunction

  function automatic logic [3:0] immAlu(input logic [5:0] o);
    case (o)
      6'b001010: return 4'b0010;
      6'b001100: return 4'b0100;
      6'b001101: return 4'b0101;
      6'b001110: return 4'b0110;
      6'b001111: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Compare process: every enabled cycle is checked at the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      vecCount++;
      hist.push_back(dutVec);
      if (dutVec !== expVec) begin
        missCount++;
        $display("[TB] FAIL cycle%0d outputs: got %b, expected %b", vecCount, dutVec, expVec);
      end
    end
  end

  task automatic applyStimulus(input logic mr, input logic [17:0] e);
    mem_ready = mr;
    expVec    = e;
    checkEn   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Model of one instruction: fetch stalls, then the per-class cycle sequence.
  task automatic runInstr(input logic [5:0] opc, input int fStall, input int mStall);
    op = opc;
    for (int i = 0; i < fStall; i++)
      applyStimulus(1'b0, mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 4'b0000, 0));
    applyStimulus(1'b1, mk(1,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 4'b0000, 0));
    applyStimulus(1'b1, mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0000, !isKnown(opc)));
    if (opc == 6'b100011 || opc == 6'b101011) begin
      applyStimulus(1'b1, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0000, 0));
      if (opc == 6'b100011) begin
        for (int i = 0; i < mStall; i++)
          applyStimulus(1'b0, mk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0));
        applyStimulus(1'b1, mk(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0));
        applyStimulus(1'b1, mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 4'b0000, 0));
      end else begin
        for (int i = 0; i < mStall; i++)
          applyStimulus(1'b0, mk(0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0));
        applyStimulus(1'b1, mk(0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0));
      end
    end else if (opc == 6'b000000) begin
      applyStimulus(1'b1, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 4'b1111, 0));
      applyStimulus(1'b1, mk(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 4'b0000, 0));
    end else if (opc == 6'b000100) begin
      applyStimulus(1'b1, mk(0,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 4'b0001, 0));
    end else if (opc == 6'b000010) begin
      applyStimulus(1'b1, mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 4'b0000, 0));
    end else if (isImm(opc)) begin
      applyStimulus(1'b1, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, immAlu(opc), 0));
      applyStimulus(1'b1, mk(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 4'b0000, 0));
    end
  endtask

  initial begin
    int b;
    vecCount  = 0;
    missCount = 0;
    checkEn   = 1'b0;
    expVec    = '0;
    reset     = 1'b0;
    op        = 6'b100011;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) applyStimulus(1'b1, 18'b0);
    reset = 1'b1;

    b = hist.size();
    runInstr(6'b100011, 0, 0);
    checkOutput("lw_c5_regwrite_memtoreg", {16'b0, hist[b+4][12], hist[b+4][10]}, 18'b11);

    b = hist.size();
    runInstr(6'b000000, 0, 0);
    checkOutput("rtype_c3_aluop", {14'b0, hist[b+2][4:1]}, 18'b1111);
    checkOutput("rtype_c4_regdst_regwrite", {16'b0, hist[b+3][11], hist[b+3][12]}, 18'b11);

    b = hist.size();
    runInstr(6'b001101, 0, 0);
    checkOutput("ori_c3_aluop_alusrcb", {12'b0, hist[b+2][4:1], hist[b+2][8:7]}, 18'b010110);

    b = hist.size();
    runInstr(6'b000100, 0, 0);
    checkOutput("beq_c3_aluop_branch_pcsrc", {11'b0, hist[b+2][4:1], hist[b+2][16], hist[b+2][6:5]}, 18'b0001101);

    b = hist.size();
    runInstr(6'b000010, 0, 0);
    checkOutput("j_c3_pcwrite_pcsrc", {15'b0, hist[b+2][17], hist[b+2][6:5]}, 18'b110);

    b = hist.size();
    runInstr(6'b101011, 0, 2);
    checkOutput("sw_memwrite_3cycles", {15'b0, hist[b+3][14], hist[b+4][14], hist[b+5][14]}, 18'b111);

    b = hist.size();
    runInstr(6'b001000, 2, 0);
    checkOutput("fetch_stall_irwrite", {16'b0, hist[b][13], hist[b+1][13]}, 18'b00);

    b = hist.size();
    runInstr(6'b111111, 0, 0);
    checkOutput("illegal_decode", {8'b0, hist[b+1][17:10], hist[b+1][0]}, 18'b1);

    runInstr(6'b001010, 0, 0);
    runInstr(6'b001100, 1, 0);
    runInstr(6'b001110, 0, 0);
    runInstr(6'b001111, 0, 0);
    runInstr(6'b100011, 1, 2);
    runInstr(6'b010101, 0, 0);

    // Reset dropped in the middle of a MEMWR stall.
    op = 6'b101011;
    applyStimulus(1'b1, mk(1,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 4'b0000, 0));
    applyStimulus(1'b1, mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 4'b0000, 0));
    applyStimulus(1'b1, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 4'b0000, 0));
    applyStimulus(1'b0, mk(0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 4'b0000, 0));
    checkEn   = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("memwr_stall_before_reset", {17'b0, memwrite}, 18'b1);
    reset = 1'b0;
    #1;
    checkOutput("memwrite_drop_on_reset", {17'b0, memwrite}, 18'b0);
    checkOutput("all_outputs_zero_in_reset", dutVec, 18'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 18'b0);
    reset = 1'b1;
    runInstr(6'b000010, 0, 0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
